apb_master_queued: RTL and testbench

//  Parametrised APB4 master: user commands enter a command queue, then run as compliant SETUP/ACCESS transfers.

---
 rtl/apb_master_queued.sv | 242 ++++++++++++++++++++++++
 tb/tb_apb_master_queued.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_queued.sv
// Queued APB4 master: commands are buffered in a FIFO and issued as SETUP/ACCESS transfers,
// with PSTRB, PSLVERR capture, wait states, a PREADY watchdog and back-to-back issue.
module apb_master_queued #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          WDOG_EN = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  if ((DATA_W % 8) != 0) begin : g_chk_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  cmd_t              cmd_in, head_cmd, next_cmd, load_cmd;
  logic              push, pop, load;

  assign cmd_in     = {cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
  assign push       = cmd_valid_i && cmd_ready_q;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head_cmd   = mem_q[rd_ptr_q];
  // With one entry left, a command pushed in the completing cycle becomes the next head directly.
  assign next_cmd   = (cnt_q > CNT_W'(1)) ? mem_q[rd_ptr_nxt] : cmd_in;

  // Command storage
  always_ff @(posedge pclk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      cnt_d    = cnt_d + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_nxt;
      cnt_d    = cnt_d - CNT_W'(1);
    end
  end

  // Transfer sequencing, watchdog and response generation
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    wdog_d        = wdog_q;
    pop           = 1'b0;
    load          = 1'b0;
    load_cmd      = head_cmd;

    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          pop         = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        end else if (WDOG_EN && (wdog_q == WD_MAX)) begin
          pop           = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (WDOG_EN) begin
          wdog_d = wdog_q + WD_W'(1);
        end

        if (pop) begin
          rsp_valid_d = 1'b1;
          if ((cnt_q > CNT_W'(1)) || push) begin
            load     = 1'b1;
            load_cmd = next_cmd;
            state_d  = ST_SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (load) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = load_cmd.write;
      paddr_d   = load_cmd.addr;
      pwdata_d  = load_cmd.wdata;
      pstrb_d   = load_cmd.write ? load_cmd.strb : '0;
      wdog_d    = '0;
    end
  end

  assign cmd_ready_d = (cnt_d != CNT_W'(DEPTH));
  assign busy_d      = (state_d != ST_IDLE) || (cnt_d != '0);

  // State and output registers
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      wdog_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      wdog_q        <= wdog_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_queued.sv
// Self-checking bench for apb_master_queued: directed vector table, corner sequences,
// and randomized traffic against a transaction-level queue model.
module tb_apb_master_queued;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_queued #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk_i(pclk), .presetn_i(presetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One clock: return at the falling edge so outputs are stable and inputs can be set.
  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    int                waits;
    logic              last_ready;
    logic [DATA_W-1:0] prd;
    logic              slverr;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    logic              exp_to;
  } vec_t;

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
  } bcmd_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    tick();
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_psel_at_n", idx), psel, 1'b0);
    tick();
    chk($sformatf("v%0d_setup_psel", idx), {psel, penable}, 2'b10);
    chk($sformatf("v%0d_paddr", idx), paddr, v.addr);
    chk($sformatf("v%0d_pwrite", idx), pwrite, v.write);
    chk($sformatf("v%0d_pstrb", idx), pstrb, v.write ? v.strb : '0);
    if (v.write) chk($sformatf("v%0d_pwdata", idx), pwdata, v.wdata);
    tick();
    chk($sformatf("v%0d_access", idx), {psel, penable}, 2'b11);
    for (int w = 0; w < v.waits; w++) begin
      pready  = 1'b0;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      tick();
      chk($sformatf("v%0d_wait%0d_rsp", idx, w), rsp_valid, 1'b0);
      chk($sformatf("v%0d_wait%0d_hold", idx, w), {psel, penable, paddr}, {2'b11, v.addr});
    end
    pready  = v.last_ready;
    pslverr = v.slverr;
    prdata  = v.prd;
    tick();
    chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err, v.exp_err);
    chk($sformatf("v%0d_rsp_timeout", idx), rsp_timeout, v.exp_to);
    pready  = 1'b0;
    pslverr = 1'b0;
    tick();
    chk($sformatf("v%0d_after", idx), {rsp_valid, busy, psel, rsp_err, rsp_timeout}, 5'b0);
  endtask

  // Transaction-level model state for the randomized phase
  bcmd_t             mq[$];
  bcmd_t             ncmd;
  logic              accepted, exp_now, exp_err, exp_to;
  logic [DATA_W-1:0] exp_rdata;
  int                waits_left, zero_cnt, rsp_n, setup_n;
  logic              prev_setup, prev_idle_nonempty;
  logic [ADDR_W-1:0] fill_addr[4];

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b1, 32'h1234, 1'b0, 32'h1234, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b1, 32'h55AA, 1'b1, 32'h55AA, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h44, 32'h11223344, 4'h5, 1, 1'b1, 32'h9999, 1'b1, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h50, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h7777, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h60, 32'h0, 4'h0, TIMEOUT - 1, 1'b1, 32'hBEEF, 1'b0, 32'hBEEF, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, psel, penable, pwrite},
        8'b0);
    chk("reset_bus", {paddr, pstrb, rsp_rdata}, '0);
    presetn = 1'b1;
    tick();
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Fill the queue while the slave stalls, then drain back-to-back
    pready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_addr[k] = ADDR_W'(32'h100 + 32'(k) * 4);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = fill_addr[k];
      tick();
      chk($sformatf("fill_ready_%0d", k), cmd_ready, (k < 3) ? 1'b1 : 1'b0);
    end
    cmd_addr = 32'hBAD0;
    tick();
    chk("fill_still_full", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    pready = 1'b1;
    prdata = 32'h0;
    rsp_n = 0;
    setup_n = 1;
    for (int c = 0; c < 20 && rsp_n < 4; c++) begin
      tick();
      if (rsp_valid) rsp_n++;
      if (psel && !penable) begin
        if (setup_n < 4) chk($sformatf("fill_order_%0d", setup_n), paddr, fill_addr[setup_n]);
        else chk("fill_extra_setup", paddr, 32'hFFFF_FFFF);
        setup_n++;
      end
      if (rsp_n < 4) chk("fill_psel_held", psel, 1'b1);
    end
    chk("fill_rsp_count", rsp_n, 4);
    pready = 1'b0;
    tick();
    tick();
    chk("fill_idle", {psel, rsp_valid, busy, cmd_ready}, 4'b0001);

    // Reset in the middle of an ACCESS with commands queued behind it
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1;
      cmd_addr  = ADDR_W'(32'h200 + 32'(k));
      tick();
    end
    cmd_valid = 1'b0;
    chk("rst_mid_in_access", {psel, penable}, 2'b11);
    presetn = 1'b0;
    #1;
    chk("rst_mid_immediate", {psel, penable, busy, rsp_valid, cmd_ready}, 5'b0);
    tick();
    presetn = 1'b1;
    pready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_mid_quiet", {psel, rsp_valid, busy}, 3'b0);
    end
    chk("rst_mid_ready", cmd_ready, 1'b1);
    pready = 1'b0;

    // Randomized traffic against the queue model
    waits_left = 0;
    zero_cnt = 0;
    prev_setup = 1'b0;
    prev_idle_nonempty = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = (i < 1880) && ($urandom_range(2, 0) != 0);
      ncmd.w = 1'($urandom);
      ncmd.a = ADDR_W'($urandom) & ~ADDR_W'(3);
      ncmd.d = DATA_W'($urandom);
      ncmd.s = STRB_W'($urandom);
      cmd_write = ncmd.w;
      cmd_addr  = ncmd.a;
      cmd_wdata = ncmd.d;
      cmd_strb  = ncmd.s;
      accepted  = cmd_valid && cmd_ready;
      exp_now   = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      exp_to    = 1'b0;
      pslverr   = 1'($urandom);
      prdata    = DATA_W'($urandom);
      if (psel && penable) begin
        if (waits_left == 0) begin
          pready    = 1'b1;
          exp_now   = 1'b1;
          exp_err   = pslverr;
          exp_rdata = (mq.size() != 0 && !mq[0].w) ? prdata : '0;
        end else begin
          pready = 1'b0;
          waits_left--;
          zero_cnt++;
          if (zero_cnt == int'(TIMEOUT)) begin
            exp_now = 1'b1;
            exp_err = 1'b1;
            exp_to  = 1'b1;
          end
        end
      end else begin
        pready = 1'($urandom);
      end
      tick();
      if (exp_now && mq.size() != 0) void'(mq.pop_front());
      if (accepted) mq.push_back(ncmd);

      chk("rnd_rsp_valid", rsp_valid, exp_now);
      if (exp_now) chk("rnd_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {exp_rdata, exp_err, exp_to});
      else chk("rnd_rsp_idle_flags", {rsp_err, rsp_timeout}, 2'b0);
      chk("rnd_cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("rnd_busy", busy, mq.size() != 0);
      if (prev_setup) chk("rnd_setup_to_access", {psel, penable}, 2'b11);
      if (prev_idle_nonempty) chk("rnd_idle_to_setup", {psel, penable}, 2'b10);
      if (exp_now && mq.size() != 0) chk("rnd_back_to_back", {psel, penable}, 2'b10);
      if (psel) begin
        if (mq.size() == 0) begin
          chk("rnd_psel_empty_queue", psel, 1'b0);
        end else begin
          chk("rnd_bus_ctrl", {paddr, pwrite, pstrb},
              {mq[0].a, mq[0].w, mq[0].w ? mq[0].s : STRB_W'(0)});
          if (mq[0].w) chk("rnd_pwdata", pwdata, mq[0].d);
        end
      end
      if (psel && !penable) begin
        waits_left = ($urandom_range(7, 0) == 0) ? 1000 : int'($urandom_range(3, 0));
        zero_cnt = 0;
      end
      prev_setup = psel && !penable;
      prev_idle_nonempty = !psel && (mq.size() != 0);
    end
    chk("rnd_drained", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
